// File: rtl/gdp_result_collector.sv
// Batch sequencer and scorer for the gdp_net classifier: fires one inference per image,
// compares each result with its label and keeps counts, a category histogram and error flags.
module gdp_result_collector #(
  parameter int N_IMAGES   = 16,
  parameter int N_CAT      = 10,
  parameter int ARM_CYCLES = 4,
  parameter int TIMEOUT    = 300000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic [3:0] i_label_in,
  output logic       o_net_start,
  output logic       o_net_trigger,
  input  logic       i_net_one_end,
  input  logic [3:0] i_net_categories,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_res_valid,
  output logic [3:0] o_res_category,
  output logic       o_res_match,
  output logic [7:0] o_image_cnt,
  output logic [7:0] o_correct_cnt,
  input  logic [3:0] i_hist_sel,
  output logic [7:0] o_hist_cnt,
  output logic       o_timeout_err,
  output logic       o_spurious_err
);

  // state  | meaning
  // IDLE   | waiting for run
  // ARM    | net_start held for ARM_CYCLES before the first trigger
  // FIRE   | one-cycle trigger pulse
  // WAIT   | waiting for one_end or timeout
  // RECORD | result presented, counters updated
  // DONE   | one-cycle batch-complete pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_WAIT,
    S_RECORD,
    S_DONE
  } state_t;

  localparam int LP_ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam int LP_TMO_W = $clog2(TIMEOUT);
  localparam logic [LP_ARM_W-1:0] LP_ARM_LOAD = LP_ARM_W'(ARM_CYCLES - 1);
  localparam logic [LP_TMO_W-1:0] LP_TMO_LOAD = LP_TMO_W'(TIMEOUT - 1);
  localparam logic [7:0] LP_N_IMG = 8'(N_IMAGES);
  localparam logic [4:0] LP_N_CAT = 5'(N_CAT);

  state_t r_state;
  state_t w_state_nxt;

  logic [LP_ARM_W-1:0] r_arm_cnt;
  logic [LP_TMO_W-1:0] r_wait_cnt;
  logic [3:0]          r_cat;
  logic                r_match;
  logic [7:0]          r_image_cnt;
  logic [7:0]          r_correct_cnt;
  logic                r_timeout_err;
  logic                r_spurious_err;
  logic [7:0]          r_hist [N_CAT];

  logic       w_start_batch;
  logic       w_tmo_expire;
  logic [7:0] w_img_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_start_batch = (r_state == S_IDLE) && i_run;
  assign w_tmo_expire  = (r_state == S_WAIT) && !i_net_one_end && (r_wait_cnt == '0);
  assign w_img_inc     = sat_inc(r_image_cnt);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_net_start   = 1'b0;
    o_net_trigger = 1'b0;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    o_res_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_run) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        o_net_start = 1'b1;
        if (r_arm_cnt == '0) w_state_nxt = S_FIRE;
      end
      S_FIRE: begin
        o_net_start   = 1'b1;
        o_net_trigger = 1'b1;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        o_net_start = 1'b1;
        if (i_net_one_end || (r_wait_cnt == '0)) w_state_nxt = S_RECORD;
      end
      S_RECORD: begin
        o_net_start = 1'b1;
        o_res_valid = 1'b1;
        w_state_nxt = (w_img_inc < LP_N_IMG) ? S_FIRE : S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        o_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Timers are down-counters: terminal count 0 marks the last ARM cycle / the WAIT expiry cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_arm_cnt      <= '0;
      r_wait_cnt     <= '0;
      r_cat          <= '0;
      r_match        <= 1'b0;
      r_image_cnt    <= '0;
      r_correct_cnt  <= '0;
      r_timeout_err  <= 1'b0;
      r_spurious_err <= 1'b0;
    end else begin
      if (w_start_batch) begin
        r_arm_cnt <= LP_ARM_LOAD;
      end else if ((r_state == S_ARM) && (r_arm_cnt != '0)) begin
        r_arm_cnt <= r_arm_cnt - LP_ARM_W'(1);
      end

      if (r_state == S_FIRE) begin
        r_wait_cnt <= LP_TMO_LOAD;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - LP_TMO_W'(1);
      end

      if ((r_state == S_WAIT) && i_net_one_end) begin
        r_cat   <= i_net_categories;
        r_match <= (i_net_categories == i_label_in) && ({1'b0, i_net_categories} < LP_N_CAT);
      end else if (w_tmo_expire) begin
        r_cat   <= 4'hF;
        r_match <= 1'b0;
      end

      if (w_start_batch) begin
        r_image_cnt   <= '0;
        r_correct_cnt <= '0;
        r_timeout_err <= 1'b0;
      end else if (r_state == S_RECORD) begin
        r_image_cnt <= w_img_inc;
        if (r_match) r_correct_cnt <= sat_inc(r_correct_cnt);
      end else if (w_tmo_expire) begin
        r_timeout_err <= 1'b1;
      end

      // A stray one_end in the same cycle as run still counts as a protocol error.
      if (i_net_one_end && (r_state != S_WAIT)) begin
        r_spurious_err <= 1'b1;
      end else if (w_start_batch) begin
        r_spurious_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_CAT; i++) r_hist[i] <= '0;
    end else begin
      for (int i = 0; i < N_CAT; i++) begin
        if (w_start_batch) begin
          r_hist[i] <= '0;
        end else if ((r_state == S_RECORD) && (r_cat == 4'(i))) begin
          r_hist[i] <= sat_inc(r_hist[i]);
        end
      end
    end
  end

  always_comb begin
    o_hist_cnt = '0;
    for (int i = 0; i < N_CAT; i++) begin
      if (i_hist_sel == 4'(i)) o_hist_cnt = r_hist[i];
    end
  end

  assign o_res_category = r_cat;
  assign o_res_match    = r_match;
  assign o_image_cnt    = r_image_cnt;
  assign o_correct_cnt  = r_correct_cnt;
  assign o_timeout_err  = r_timeout_err;
  assign o_spurious_err = r_spurious_err;

endmodule

// File: tb/tb_gdp_result_collector.sv
// Directed bench for gdp_result_collector: a stub network answers each trigger, expected
// results go into a scoreboard queue and are checked when res_valid pulses.
module tb_gdp_result_collector;

  localparam int LP_NIMG = 16;
  localparam int LP_NCAT = 10;
  localparam int LP_ARM  = 4;
  localparam int LP_TMO  = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [3:0] label_in;
  logic       net_start;
  logic       net_trigger;
  logic       one_end;
  logic [3:0] net_cat;
  logic       busy;
  logic       done;
  logic       res_valid;
  logic [3:0] res_category;
  logic       res_match;
  logic [7:0] image_cnt;
  logic [7:0] correct_cnt;
  logic [3:0] hist_sel;
  logic [7:0] hist_cnt;
  logic       timeout_err;
  logic       spurious_err;

  always #50 clk = ~clk;

  gdp_result_collector #(
    .N_IMAGES  (LP_NIMG),
    .N_CAT     (LP_NCAT),
    .ARM_CYCLES(LP_ARM),
    .TIMEOUT   (LP_TMO)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_run           (run),
    .i_label_in      (label_in),
    .o_net_start     (net_start),
    .o_net_trigger   (net_trigger),
    .i_net_one_end   (one_end),
    .i_net_categories(net_cat),
    .o_busy          (busy),
    .o_done          (done),
    .o_res_valid     (res_valid),
    .o_res_category  (res_category),
    .o_res_match     (res_match),
    .o_image_cnt     (image_cnt),
    .o_correct_cnt   (correct_cnt),
    .i_hist_sel      (hist_sel),
    .o_hist_cnt      (hist_cnt),
    .o_timeout_err   (timeout_err),
    .o_spurious_err  (spurious_err)
  );

  int checks   = 0;
  int failures = 0;

  logic [4:0] sb_q[$];
  logic [4:0] mon_e;
  int         valid_seen;

  logic [3:0] cat_tab [LP_NIMG];
  logic [3:0] lab_tab [LP_NIMG];
  int         dly_tab [LP_NIMG];
  bit         drop_tab[LP_NIMG];
  int         run_in_wait_img;
  bit         spur_arm;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      valid_seen++;
      chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("res_category", res_category, mon_e[3:0]);
        chk("res_match", res_match, mon_e[4]);
      end
    end
  end

  task automatic run_batch(input string nm, input int abort_img);
    int         exp_hist[16];
    int         exp_corr;
    bit         exp_to;
    int         n;
    logic       m;
    logic [3:0] c;
    logic [3:0] l;
    exp_corr = 0;
    exp_to   = 1'b0;
    foreach (exp_hist[i]) exp_hist[i] = 0;
    valid_seen = 0;

    run = 1'b1;
    step();
    run = 1'b0;
    chk({nm, "_busy_on"}, busy, 1);
    chk({nm, "_start_on"}, net_start, 1);
    chk({nm, "_img_clr"}, image_cnt, 0);
    chk({nm, "_tmo_clr"}, timeout_err, 0);
    chk({nm, "_spur_clr"}, spurious_err, 0);
    if (spur_arm) begin
      net_cat  = 4'd3;
      label_in = 4'd3;
      one_end  = 1'b1;
    end
    for (int i = 0; i < LP_ARM; i++) begin
      chk({nm, "_arm_no_trig"}, net_trigger, 0);
      step();
      one_end = 1'b0;
    end
    chk({nm, "_first_trig"}, net_trigger, 1);

    for (int img = 0; img < LP_NIMG; img++) begin
      if (img == abort_img) begin
        step();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk({nm, "_rst_start"}, net_start, 0);
        chk({nm, "_rst_busy"}, busy, 0);
        chk({nm, "_rst_img"}, image_cnt, 0);
        chk({nm, "_rst_corr"}, correct_cnt, 0);
        chk({nm, "_rst_hist"}, hist_cnt, 0);
        chk({nm, "_rst_sb"}, sb_q.size(), 0);
        step();
        reset = 1'b0;
        return;
      end
      if (drop_tab[img]) begin
        sb_q.push_back({1'b0, 4'hF});
        exp_to = 1'b1;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
          step();
          n++;
        end
        chk({nm, "_tmo_latency"}, n, LP_TMO + 1);
        chk({nm, "_tmo_flag"}, timeout_err, 1);
      end else begin
        c = cat_tab[img];
        l = lab_tab[img];
        for (int d = 0; d < dly_tab[img]; d++) begin
          step();
          run = (img == run_in_wait_img) && (d == 3);
        end
        run = 1'b0;
        m = (c == l) && (c < 4'(LP_NCAT));
        sb_q.push_back({m, c});
        if (m) exp_corr++;
        if (c < 4'(LP_NCAT)) exp_hist[c]++;
        net_cat  = c;
        label_in = l;
        one_end  = 1'b1;
        step();
        one_end  = 1'b0;
        net_cat  = 4'($urandom);
        label_in = 4'($urandom);
        chk({nm, "_record"}, res_valid, 1);
      end
      step();
      if (img < LP_NIMG - 1) begin
        chk({nm, "_next_trig"}, net_trigger, 1);
      end else begin
        chk({nm, "_done_pulse"}, done, 1);
        chk({nm, "_busy_in_done"}, busy, 1);
      end
    end
    step();
    chk({nm, "_done_end"}, done, 0);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_start_end"}, net_start, 0);
    chk({nm, "_image_cnt"}, image_cnt, LP_NIMG);
    chk({nm, "_correct_cnt"}, correct_cnt, exp_corr);
    chk({nm, "_valid_pulses"}, valid_seen, LP_NIMG);
    chk({nm, "_sb_drained"}, sb_q.size(), 0);
    chk({nm, "_timeout_err"}, timeout_err, exp_to);
    chk({nm, "_spurious_err"}, spurious_err, spur_arm);
    for (int s = 0; s < 16; s++) begin
      hist_sel = 4'(s);
      #1;
      chk({nm, "_hist"}, hist_cnt, (s < LP_NCAT) ? exp_hist[s] : 0);
    end
  endtask

  initial begin
    reset           = 1'b1;
    run             = 1'b0;
    one_end         = 1'b0;
    label_in        = '0;
    net_cat         = '0;
    hist_sel        = '0;
    run_in_wait_img = -1;
    spur_arm        = 1'b0;
    repeat (3) step();
    chk("reset_net_start", net_start, 0);
    chk("reset_trigger", net_trigger, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_category", res_category, 0);
    chk("reset_res_match", res_match, 0);
    chk("reset_image_cnt", image_cnt, 0);
    chk("reset_correct_cnt", correct_cnt, 0);
    chk("reset_hist", hist_cnt, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_spurious_err", spurious_err, 0);
    reset = 1'b0;
    step();
    step();

    net_cat  = 4'd3;
    label_in = 4'd3;
    one_end  = 1'b1;
    step();
    one_end  = 1'b0;
    step();
    hist_sel = 4'd3;
    #1;
    chk("idle_spurious", spurious_err, 1);
    chk("idle_spur_img", image_cnt, 0);
    chk("idle_spur_hist", hist_cnt, 0);
    chk("idle_spur_busy", busy, 0);

    for (int i = 0; i < LP_NIMG; i++) begin
      cat_tab[i] = 4'd7; lab_tab[i] = 4'd7; dly_tab[i] = 20; drop_tab[i] = 1'b0;
    end
    run_batch("basic", -1);
    repeat (3) step();

    for (int i = 0; i < LP_NIMG; i++) begin
      cat_tab[i] = 4'(i % 10); lab_tab[i] = 4'(i % 10); dly_tab[i] = 20; drop_tab[i] = 1'b0;
    end
    drop_tab[2]     = 1'b1;
    run_in_wait_img = 3;
    run_batch("tmo", -1);

    run_in_wait_img = -1;
    spur_arm        = 1'b1;
    for (int i = 0; i < LP_NIMG; i++) begin
      cat_tab[i] = 4'd3; lab_tab[i] = 4'(i); dly_tab[i] = 20; drop_tab[i] = 1'b0;
    end
    run_batch("b2b", -1);
    spur_arm = 1'b0;
    repeat (3) step();

    for (int i = 0; i < LP_NIMG; i++) begin
      cat_tab[i] = 4'(i); lab_tab[i] = 4'(i); dly_tab[i] = 7; drop_tab[i] = 1'b0;
    end
    dly_tab[0] = LP_TMO;
    run_batch("inval", -1);
    repeat (3) step();

    for (int i = 0; i < LP_NIMG; i++) begin
      cat_tab[i] = 4'd1; lab_tab[i] = 4'd1; dly_tab[i] = 5; drop_tab[i] = 1'b0;
    end
    hist_sel = 4'd1;
    run_batch("abort", 5);
    repeat (2) step();

    for (int i = 0; i < LP_NIMG; i++) begin
      cat_tab[i] = 4'd2; lab_tab[i] = 4'd2; dly_tab[i] = 20; drop_tab[i] = 1'b0;
    end
    run_batch("after_rst", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
